// File: rtl/imem_responder_if.sv
// Fetch-side instruction request bundle and the interface that carries it.
// Ports: imem_in (fetch request), imem_out (response); master = fetch, slave = responder.
package imem_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

interface imem_responder_if;
    import imem_pkg::*;

    mem_in_type  imem_in;
    mem_out_type imem_out;

    modport master (
        output imem_in,
        input  imem_out
    );

    modport slave (
        input  imem_in,
        output imem_out
    );

endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time to a variable-latency backing port,
// dropping stale data on spec/fence/clear. Ports: clock, reset (sync, active-low),
// imem (slave: request in / response out), bmem_valid/addr out, bmem_ready/rdata in.
module imem_responder
    import imem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    imem_responder_if.slave   imem,
    output logic              bmem_valid,
    output logic [31:0]       bmem_addr,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic        pend;
    logic [31:0] pend_addr;

    logic        legal;
    logic        kill;
    logic        respond;
    logic        nxt_pend;
    logic [31:0] nxt_pend_addr;

    // Write data is never used by an instruction port.
    logic unused_wdata;
    assign unused_wdata = ^imem.imem_in.mem_wdata;

    always_comb begin
        legal = imem.imem_in.mem_valid
              & imem.imem_in.mem_instr
              & (imem.imem_in.mem_wstrb == 4'h0);
        kill  = ~imem.imem_in.mem_valid
              | imem.imem_in.mem_spec
              | imem.imem_in.mem_fence;
        respond = (state == BUSY) & bmem_ready & ~kill;
        // A redirect seen while an access is outstanding replaces
        // whatever was queued before; the latest one wins.
        nxt_pend      = pend;
        nxt_pend_addr = pend_addr;
        if (kill) begin
            nxt_pend = legal;
            if (legal) begin
                nxt_pend_addr = imem.imem_in.mem_addr;
            end
        end
    end

    // Backing side depends only on registered state.
    assign bmem_valid = (state != IDLE);
    assign bmem_addr  = bmem_valid ? addr : 32'h0;

    assign imem.imem_out.mem_ready = respond;
    assign imem.imem_out.mem_rdata = respond ? bmem_rdata : 32'h0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= 32'h0;
            pend      <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (legal) begin
                        addr  <= imem.imem_in.mem_addr;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bmem_ready) begin
                        if (kill && legal) begin
                            // Slot just freed: start the redirect now.
                            addr <= imem.imem_in.mem_addr;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (kill) begin
                        // Access in flight cannot be aborted.
                        state <= DROP;
                        pend  <= legal;
                        if (legal) begin
                            pend_addr <= imem.imem_in.mem_addr;
                        end
                    end
                end
                DROP: begin
                    if (bmem_ready) begin
                        pend <= 1'b0;
                        if (nxt_pend) begin
                            addr  <= nxt_pend_addr;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        pend      <= nxt_pend;
                        pend_addr <= nxt_pend_addr;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder.
// Each scenario task drives vectors and checks outputs against hand-computed values.
module tb_imem_responder;
    import imem_pkg::*;

    logic        clock;
    logic        reset;
    logic        bmem_valid;
    logic [31:0] bmem_addr;
    logic        bmem_ready;
    logic [31:0] bmem_rdata;

    int passed;
    int total;

    imem_responder_if bus ();

    imem_responder dut (
        .clock      (clock),
        .reset      (reset),
        .imem       (bus.slave),
        .bmem_valid (bmem_valid),
        .bmem_addr  (bmem_addr),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic f,
                         input logic i, input logic [31:0] a,
                         input logic [3:0] w);
        bus.imem_in.mem_valid = v;
        bus.imem_in.mem_spec  = s;
        bus.imem_in.mem_fence = f;
        bus.imem_in.mem_instr = i;
        bus.imem_in.mem_addr  = a;
        bus.imem_in.mem_wdata = 32'h0;
        bus.imem_in.mem_wstrb = w;
    endtask

    task automatic bmem(input logic r, input logic [31:0] d);
        bmem_ready = r;
        bmem_rdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(1, 32'hFFFF_FFFF);
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL reset_bvalid got=%0b exp=0", bmem_valid);
        else passed++;
        total++;
        if (bmem_addr !== 32'h0) $display("FAIL reset_baddr got=%h exp=0", bmem_addr);
        else passed++;
        total++;
        if (bus.imem_out.mem_ready !== 1'b0)
            $display("FAIL reset_ready got=%0b exp=0", bus.imem_out.mem_ready);
        else passed++;
        total++;
        if (bus.imem_out.mem_rdata !== 32'h0)
            $display("FAIL reset_rdata got=%h exp=0", bus.imem_out.mem_rdata);
        else passed++;
        step();
        bmem(0, 32'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL idle_bready_ignored got=%0b exp=0", bmem_valid);
        else passed++;
    endtask

    task automatic test_single();
        drive(1, 0, 0, 1, 32'h100, 4'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL single_t_bvalid got=%0b exp=0", bmem_valid);
        else passed++;
        step();
        bmem(1, 32'h0000_0013);
        #1;
        total++;
        if (bmem_addr !== 32'h100) $display("FAIL single_baddr got=%h exp=100", bmem_addr);
        else passed++;
        total++;
        if (bus.imem_out.mem_ready !== 1'b1)
            $display("FAIL single_ready got=%0b exp=1", bus.imem_out.mem_ready);
        else passed++;
        total++;
        if (bus.imem_out.mem_rdata !== 32'h13)
            $display("FAIL single_rdata got=%h exp=13", bus.imem_out.mem_rdata);
        else passed++;
        step();
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(0, 32'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL single_idle got=%0b exp=0", bmem_valid);
        else passed++;
    endtask

    task automatic test_latency();
        int pulses;
        int bad;
        pulses = 0;
        bad = 0;
        drive(1, 0, 0, 1, 32'h200, 4'h0);
        step();
        for (int c = 1; c <= 3; c++) begin
            bmem(c == 3, 32'hCAFE_0200);
            #1;
            if (bmem_valid !== 1'b1 || bmem_addr !== 32'h200) bad++;
            if (bus.imem_out.mem_ready === 1'b1) begin
                pulses++;
                if (c != 3) bad++;
                if (bus.imem_out.mem_rdata !== 32'hCAFE_0200) bad++;
            end
            step();
        end
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(0, 32'h0);
        #1;
        total++;
        if (bad !== 0) $display("FAIL lat_stable got=%0d errors exp=0", bad);
        else passed++;
        total++;
        if (pulses !== 1) $display("FAIL lat_pulses got=%0d exp=1", pulses);
        else passed++;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL lat_idle got=%0b exp=0", bmem_valid);
        else passed++;
    endtask

    task automatic test_redirect();
        drive(1, 0, 0, 1, 32'h300, 4'h0);
        step();
        drive(1, 1, 0, 1, 32'h80, 4'h0);
        #1;
        total++;
        if (bus.imem_out.mem_ready !== 1'b0 || bmem_addr !== 32'h300)
            $display("FAIL redir_t1 got=%0b/%h exp=0/300",
                     bus.imem_out.mem_ready, bmem_addr);
        else passed++;
        step();
        drive(1, 0, 0, 1, 32'h80, 4'h0);
        bmem(1, 32'h0000_DEAD);
        #1;
        total++;
        if (bus.imem_out.mem_ready !== 1'b0 || bus.imem_out.mem_rdata !== 32'h0)
            $display("FAIL redir_drop got=%0b/%h exp=0/0",
                     bus.imem_out.mem_ready, bus.imem_out.mem_rdata);
        else passed++;
        step();
        bmem(0, 32'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b1 || bmem_addr !== 32'h80)
            $display("FAIL redir_new got=%0b/%h exp=1/80", bmem_valid, bmem_addr);
        else passed++;
        step();
        bmem(1, 32'h0008_0080);
        #1;
        total++;
        if (bus.imem_out.mem_ready !== 1'b1 || bus.imem_out.mem_rdata !== 32'h0008_0080)
            $display("FAIL redir_resp got=%0b/%h exp=1/00080080",
                     bus.imem_out.mem_ready, bus.imem_out.mem_rdata);
        else passed++;
        step();
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(0, 32'h0);
        // Kill coinciding with completion restarts from the same slot.
        step();
        drive(1, 0, 0, 1, 32'h700, 4'h0);
        step();
        drive(1, 1, 0, 1, 32'h7A0, 4'h0);
        bmem(1, 32'h0BAD_0700);
        #1;
        total++;
        if (bus.imem_out.mem_ready !== 1'b0)
            $display("FAIL kill_ready_resp got=%0b exp=0", bus.imem_out.mem_ready);
        else passed++;
        step();
        drive(1, 0, 0, 1, 32'h7A0, 4'h0);
        bmem(0, 32'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b1 || bmem_addr !== 32'h7A0)
            $display("FAIL kill_ready_new got=%0b/%h exp=1/7a0", bmem_valid, bmem_addr);
        else passed++;
        bmem(1, 32'h0000_07A0);
        step();
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(0, 32'h0);
        step();
    endtask

    task automatic test_back_to_back();
        int seen40;
        seen40 = 0;
        drive(1, 0, 0, 1, 32'h500, 4'h0);
        step();
        drive(1, 1, 0, 1, 32'h40, 4'h0);
        #1;
        if (bmem_valid && bmem_addr == 32'h40) seen40++;
        step();
        drive(1, 0, 1, 1, 32'h44, 4'h0);
        #1;
        if (bmem_valid && bmem_addr == 32'h40) seen40++;
        total++;
        if (bmem_addr !== 32'h500 || bus.imem_out.mem_ready !== 1'b0)
            $display("FAIL b2b_drop got=%h/%0b exp=500/0",
                     bmem_addr, bus.imem_out.mem_ready);
        else passed++;
        step();
        drive(1, 0, 0, 1, 32'h44, 4'h0);
        bmem(1, 32'h0BAD_0500);
        #1;
        if (bmem_valid && bmem_addr == 32'h40) seen40++;
        step();
        bmem(0, 32'h0);
        #1;
        if (bmem_valid && bmem_addr == 32'h40) seen40++;
        total++;
        if (bmem_valid !== 1'b1 || bmem_addr !== 32'h44)
            $display("FAIL b2b_issue got=%0b/%h exp=1/44", bmem_valid, bmem_addr);
        else passed++;
        step();
        bmem(1, 32'h0000_0044);
        #1;
        if (bmem_valid && bmem_addr == 32'h40) seen40++;
        total++;
        if (bus.imem_out.mem_ready !== 1'b1 || bus.imem_out.mem_rdata !== 32'h44)
            $display("FAIL b2b_resp got=%0b/%h exp=1/44",
                     bus.imem_out.mem_ready, bus.imem_out.mem_rdata);
        else passed++;
        total++;
        if (seen40 !== 0) $display("FAIL b2b_no40 got=%0d exp=0", seen40);
        else passed++;
        step();
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(0, 32'h0);
        step();
    endtask

    task automatic test_clear();
        drive(1, 0, 0, 1, 32'h600, 4'h0);
        step();
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        step();
        #1;
        total++;
        if (bmem_valid !== 1'b1 || bmem_addr !== 32'h600)
            $display("FAIL clear_drop got=%0b/%h exp=1/600", bmem_valid, bmem_addr);
        else passed++;
        step();
        bmem(1, 32'h0BAD_0600);
        #1;
        total++;
        if (bus.imem_out.mem_ready !== 1'b0)
            $display("FAIL clear_noresp got=%0b exp=0", bus.imem_out.mem_ready);
        else passed++;
        step();
        bmem(0, 32'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL clear_idle got=%0b exp=0", bmem_valid);
        else passed++;
    endtask

    task automatic test_reset_busy();
        drive(1, 0, 0, 1, 32'h800, 4'h0);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(1, 32'h0000_0BAD);
        #1;
        total++;
        if (bmem_valid !== 1'b0 || bmem_addr !== 32'h0)
            $display("FAIL rstbusy_b got=%0b/%h exp=0/0", bmem_valid, bmem_addr);
        else passed++;
        total++;
        if (bus.imem_out.mem_ready !== 1'b0 || bus.imem_out.mem_rdata !== 32'h0)
            $display("FAIL rstbusy_resp got=%0b/%h exp=0/0",
                     bus.imem_out.mem_ready, bus.imem_out.mem_rdata);
        else passed++;
        step();
        bmem(0, 32'h0);
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL rstbusy_late got=%0b exp=0", bmem_valid);
        else passed++;
    endtask

    task automatic test_illegal();
        drive(1, 0, 0, 1, 32'h900, 4'hF);
        step();
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL illegal_wstrb got=%0b exp=0", bmem_valid);
        else passed++;
        drive(1, 0, 0, 0, 32'h904, 4'h0);
        step();
        #1;
        total++;
        if (bmem_valid !== 1'b0) $display("FAIL illegal_data got=%0b exp=0", bmem_valid);
        else passed++;
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 4'h0);
        bmem(0, 32'h0);
        test_reset();
        test_single();
        test_latency();
        test_redirect();
        test_back_to_back();
        test_clear();
        test_reset_busy();
        test_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
